// File: rtl/watch_mode_sequencer.sv
// Watch mode sequencer: steps through NUM_MODES display modes on rising edges
// of the mode button, honours per-mode "done" permission to leave, and
// auto-returns to Normal (mode 0) after an idle period in selected modes.
module watch_mode_sequencer #(
  parameter int                   NUM_MODES        = 4,
  parameter int                   MODE_W           = $clog2(NUM_MODES),
  parameter int                   TIMEOUT_CYCLES   = 1000,
  parameter logic [NUM_MODES-1:0] TIMEOUT_MASK     = 4'b0110,
  parameter logic [NUM_MODES-1:0] SHOW_NORMAL_MASK = 4'b1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [NUM_MODES-1:0] mode_done,
  input  logic                 activity,
  output logic [NUM_MODES-1:0] mode_en,
  output logic [MODE_W-1:0]    cur_mode,
  output logic                 mode_changed,
  output logic                 timeout_evt
);

  // Mode-indexed tables are padded to the full index range so that any
  // cur_mode value (including unused encodings) selects a defined bit.
  localparam int MODES_P2 = 1 << MODE_W;

  // Idle counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int               CNT_MAX = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam int               CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  localparam logic [MODE_W-1:0] MODE_ZERO = {MODE_W{1'b0}};
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  function automatic logic [MODES_P2-1:0] ext_mask(input logic [NUM_MODES-1:0] m);
    logic [MODES_P2-1:0] r;
    r                = {MODES_P2{1'b0}};
    r[NUM_MODES-1:0] = m;
    return r;
  endfunction

  // Valid encodings, auto-return enables (mode 0 never auto-returns), and
  // modes that keep the Normal display enabled alongside their own.
  localparam logic [MODES_P2-1:0] VALID_EXT = ext_mask({NUM_MODES{1'b1}});
  localparam logic [MODES_P2-1:0] TO_EXT    = ext_mask({TIMEOUT_MASK[NUM_MODES-1:1], 1'b0});
  localparam logic [MODES_P2-1:0] SHOW_EXT  = ext_mask(SHOW_NORMAL_MASK);

  // One-hot enable for a mode; an unused encoding shows Normal only.
  function automatic logic [NUM_MODES-1:0] decode_en(input logic [MODE_W-1:0] m);
    logic [NUM_MODES-1:0] en;
    en = {NUM_MODES{1'b0}};
    if (VALID_EXT[m]) begin
      for (int i = 0; i < NUM_MODES; i++) begin
        en[i] = (m == MODE_W'(i));
      end
      en[0] = en[0] | SHOW_EXT[m];
    end else begin
      en[0] = 1'b1;
    end
    return en;
  endfunction

  logic                 mode_prev_q;
  logic [MODE_W-1:0]    cur_mode_q,     cur_mode_d;
  logic [NUM_MODES-1:0] mode_en_q,      mode_en_d;
  logic                 mode_changed_q, mode_changed_d;
  logic                 timeout_evt_q,  timeout_evt_d;
  logic [CNT_W-1:0]     cnt_q,          cnt_d;

  logic [MODES_P2-1:0]  done_ext_s;
  logic                 adv_edge_s;
  logic                 valid_s;
  logic                 adv_ok_s;
  logic                 to_en_s;
  logic                 auto_ret_s;

  // Next-state logic: advance beats activity, activity beats auto-return.
  always_comb begin
    done_ext_s = ext_mask(mode_done);
    adv_edge_s = mode & ~mode_prev_q;
    valid_s    = VALID_EXT[cur_mode_q];
    adv_ok_s   = adv_edge_s & valid_s &
                 ((cur_mode_q == MODE_ZERO) | done_ext_s[cur_mode_q]);
    to_en_s    = (TIMEOUT_CYCLES != 0) & valid_s & TO_EXT[cur_mode_q];
    auto_ret_s = to_en_s & (cnt_q == CNT_TOP) & ~activity & ~adv_edge_s;

    if (!valid_s) begin
      cur_mode_d = MODE_ZERO;
    end else if (adv_ok_s) begin
      cur_mode_d = (cur_mode_q == LAST_MODE) ? MODE_ZERO : (cur_mode_q + MODE_W'(1));
    end else if (activity) begin
      cur_mode_d = cur_mode_q;
    end else if (auto_ret_s) begin
      cur_mode_d = MODE_ZERO;
    end else begin
      cur_mode_d = cur_mode_q;
    end

    mode_changed_d = (cur_mode_d != cur_mode_q);
    timeout_evt_d  = auto_ret_s & ~adv_ok_s;
    mode_en_d      = decode_en(cur_mode_d);

    // Counter idles at 0 outside timed modes and restarts on any interaction.
    if (mode_changed_d || activity || adv_edge_s || !to_en_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_TOP) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and registered outputs; mode_prev resets high so a held button needs a re-press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_prev_q    <= 1'b1;
      cur_mode_q     <= MODE_ZERO;
      mode_en_q      <= NUM_MODES'(1);
      mode_changed_q <= 1'b0;
      timeout_evt_q  <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
    end else begin
      mode_prev_q    <= mode;
      cur_mode_q     <= cur_mode_d;
      mode_en_q      <= mode_en_d;
      mode_changed_q <= mode_changed_d;
      timeout_evt_q  <= timeout_evt_d;
      cnt_q          <= cnt_d;
    end
  end

  assign cur_mode     = cur_mode_q;
  assign mode_en      = mode_en_q;
  assign mode_changed = mode_changed_q;
  assign timeout_evt  = timeout_evt_q;

endmodule

// File: tb/tb_watch_mode_sequencer.sv
// Scoreboard bench for watch_mode_sequencer: each stimulus cycle pushes the
// hand-computed outputs expected after the next rising edge; a monitor pops
// and compares on every falling edge.
module tb_watch_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] mode_done;
  logic       activity;
  logic [3:0] mode_en;
  logic [1:0] cur_mode;
  logic       mode_changed;
  logic       timeout_evt;

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] act_v;
  logic       stim_done;
  int         n_vec;
  int         n_fail;

  localparam logic [3:0] D = 4'b1111;

  watch_mode_sequencer #(
    .NUM_MODES       (4),
    .MODE_W          (2),
    .TIMEOUT_CYCLES  (8),
    .TIMEOUT_MASK    (4'b0110),
    .SHOW_NORMAL_MASK(4'b1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .mode_done   (mode_done),
    .activity    (activity),
    .mode_en     (mode_en),
    .cur_mode    (cur_mode),
    .mode_changed(mode_changed),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after a falling edge and queue the
  // outputs expected after the following rising edge.
  task automatic step(input logic m, input logic a, input logic [3:0] d,
                      input logic [1:0] em, input logic [3:0] een,
                      input logic ec, input logic et);
    @(negedge clk);
    #1;
    mode      = m;
    activity  = a;
    mode_done = d;
    exp_q.push_back({em, een, ec, et});
  endtask

  // Monitor: compare one queued expectation per falling edge; ends the run.
  always @(negedge clk) begin
    if (stim_done) begin
      if (exp_q.size() != 0) begin
        n_vec  = n_vec + 1;
        n_fail = n_fail + 1;
        $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end else if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {cur_mode, mode_en, mode_changed, timeout_evt};
      n_vec = n_vec + 1;
      if (act_v !== exp_v) begin
        n_fail = n_fail + 1;
        $display("FAIL vec %0d @%0t: got cur=%0d en=%b chg=%b tevt=%b, want cur=%0d en=%b chg=%b tevt=%b",
                 n_vec, $time, act_v[7:6], act_v[5:2], act_v[1], act_v[0],
                 exp_v[7:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_fail    = 0;
    stim_done = 1'b0;
    rst       = 1'b0;
    mode      = 1'b0;
    activity  = 1'b0;
    mode_done = 4'b0000;
    exp_q.push_back({2'd0, 4'b0001, 1'b0, 1'b0});   // reset state
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Full cycle through all modes with 1-cycle presses.
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd3, 4'b1001, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd3, 4'b1001, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);

    // Mode 1 blocked by mode_done, held button must be released first.
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 2'd1, 4'b0010, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b1, 4'b0000, 2'd1, 4'b0010, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'b0010, 2'd2, 4'b0100, 1'b1, 1'b0);

    // Mode 2 idle timeout: 8 edges after entry.
    repeat (7) step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b1, 1'b1);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);

    // Mode 2 again, activity on the 5th idle cycle restarts the count.
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b1, 1'b1);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);

    // Mode 3 has no timeout: 50 idle cycles, then wrap to 0.
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd3, 4'b1001, 1'b1, 1'b0);
    repeat (50) step(1'b0, 1'b0, D, 2'd3, 4'b1001, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd0, 4'b0001, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);

    // Mode 1 at count 7: advance wins over auto-return, count restarts in 2;
    // then activity at count 7 wins over auto-return.
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b1, 1'b1);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);

    // Mid-count reset in mode 2 with the button held through release.
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, D, 2'd2, 4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mode = 1'b1;
    exp_q.push_back({2'd0, 4'b0001, 1'b0, 1'b0});   // checked before next rising edge
    @(posedge clk);
    #1;
    exp_q.push_back({2'd0, 4'b0001, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step(1'b1, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 1'b0, D, 2'd0, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, D, 2'd1, 4'b0010, 1'b1, 1'b0);
    step(1'b0, 1'b0, D, 2'd1, 4'b0010, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    stim_done = 1'b1;
  end

endmodule
